// File: rtl/multichannel_envelope_pkg.sv
// Shared types and helpers for the multichannel envelope generator.
package multichannel_envelope_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SUSTAIN,
    RELEASE,
    DONE
  } env_state_e;

  // A programmed duration of 0 behaves as a one-tick segment.
  function automatic logic [31:0] eff_dur(input logic [31:0] dur);
    return (dur == '0) ? 32'd1 : dur;
  endfunction

  function automatic logic is_active(input env_state_e s);
    return (s == RUN) || (s == SUSTAIN) || (s == RELEASE);
  endfunction

endpackage

// File: rtl/multichannel_envelope_if.sv
// Control/data bundle between the envelope generator and its host.
interface multichannel_envelope_if #(
  parameter int unsigned N_CHANNELS = 4,
  parameter int unsigned N_SEGMENTS = 8,
  parameter int unsigned GAIN_WIDTH = 16,
  parameter int unsigned DUR_WIDTH  = 16
);
  localparam int unsigned CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  logic                                       sample_tick;
  logic [N_CHANNELS-1:0]                      key_on;
  logic [N_CHANNELS-1:0]                      retrigger;
  logic [N_CHANNELS*N_SEGMENTS*GAIN_WIDTH-1:0] seg_gain;
  logic [N_CHANNELS*N_SEGMENTS*DUR_WIDTH-1:0]  seg_dur;
  logic [GAIN_WIDTH-1:0]                      out_gain;
  logic [CH_W-1:0]                            out_ch;
  logic                                       out_valid;
  logic [N_CHANNELS-1:0]                      active;
  logic                                       busy;
  logic                                       overrun;

  modport master (
    output sample_tick, key_on, retrigger, seg_gain, seg_dur,
    input  out_gain, out_ch, out_valid, active, busy, overrun
  );

  modport slave (
    input  sample_tick, key_on, retrigger, seg_gain, seg_dur,
    output out_gain, out_ch, out_valid, active, busy, overrun
  );

endinterface

// File: rtl/multichannel_envelope_env_step.sv
// Combinational next-state and target gain for one voice; shared across all slots.
module env_step
  import multichannel_envelope_pkg::*;
#(
  parameter int unsigned N_SEGMENTS  = 8,
  parameter int unsigned SUSTAIN_SEG = 3,
  parameter int unsigned GAIN_WIDTH  = 16,
  parameter int unsigned DUR_WIDTH   = 16,
  localparam int unsigned SEG_W = (N_SEGMENTS > 1) ? $clog2(N_SEGMENTS) : 1
) (
  input  env_state_e                     cur_state,
  input  logic [SEG_W-1:0]               cur_seg,
  input  logic [DUR_WIDTH-1:0]           cur_count,
  input  logic                           cur_prev_key,
  input  logic                           key,
  input  logic                           retrig,
  input  logic [N_SEGMENTS*GAIN_WIDTH-1:0] gains,
  input  logic [N_SEGMENTS*DUR_WIDTH-1:0]  durs,
  output env_state_e                     nxt_state,
  output logic [SEG_W-1:0]               nxt_seg,
  output logic [DUR_WIDTH-1:0]           nxt_count,
  output logic                           nxt_prev_key,
  output logic [GAIN_WIDTH-1:0]          gain
);

  logic [DUR_WIDTH-1:0] dur;
  logic [DUR_WIDTH-1:0] count_inc;
  logic                 seg_done;
  logic                 trigger;

  assign dur       = durs[cur_seg*DUR_WIDTH +: DUR_WIDTH];
  assign seg_done  = 32'(cur_count) >= eff_dur(32'(dur));
  assign count_inc = (cur_count == '1) ? cur_count : cur_count + 1'b1;
  assign trigger   = retrig | (key & ~cur_prev_key);

  always_comb begin
    nxt_state    = cur_state;
    nxt_seg      = cur_seg;
    nxt_count    = cur_count;
    nxt_prev_key = key;

    if (trigger) begin
      nxt_state = (SUSTAIN_SEG == 0) ? SUSTAIN : RUN;
      nxt_seg   = '0;
      nxt_count = DUR_WIDTH'(1);
    end else if (!key && (cur_state == RUN || cur_state == SUSTAIN)) begin
      nxt_state = RELEASE;
      nxt_seg   = SEG_W'(SUSTAIN_SEG + 1);
      nxt_count = DUR_WIDTH'(1);
    end else begin
      case (cur_state)
        RUN: begin
          if (seg_done) begin
            nxt_seg   = cur_seg + 1'b1;
            nxt_count = DUR_WIDTH'(1);
            if (32'(cur_seg) + 32'd1 == SUSTAIN_SEG) nxt_state = SUSTAIN;
          end else begin
            nxt_count = count_inc;
          end
        end
        RELEASE: begin
          if (seg_done) begin
            nxt_count = DUR_WIDTH'(1);
            if (32'(cur_seg) == N_SEGMENTS - 1) nxt_state = DONE;
            else                                nxt_seg   = cur_seg + 1'b1;
          end else begin
            nxt_count = count_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gain = '0;
    if (nxt_state != IDLE && nxt_state != DONE)
      gain = gains[nxt_seg*GAIN_WIDTH +: GAIN_WIDTH];
  end

endmodule

// File: rtl/multichannel_envelope.sv
// Time-multiplexed N-voice envelope generator: one voice per clock after each sample tick.
// Optional gain smoothing enabled by defining MULTICHANNEL_ENVELOPE_SMOOTHING_EN.
module multichannel_envelope
  import multichannel_envelope_pkg::*;
#(
  parameter int unsigned N_CHANNELS  = 4,
  parameter int unsigned N_SEGMENTS  = 8,
  parameter int unsigned SUSTAIN_SEG = 3,
  parameter int unsigned GAIN_WIDTH  = 16,
  parameter int unsigned DUR_WIDTH   = 16
) (
  input logic                   clk,
  input logic                   reset,
  multichannel_envelope_if.slave bus
);

  localparam int unsigned CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int unsigned SEG_W = (N_SEGMENTS > 1) ? $clog2(N_SEGMENTS) : 1;
  localparam int unsigned VG    = N_SEGMENTS * GAIN_WIDTH;
  localparam int unsigned VD    = N_SEGMENTS * DUR_WIDTH;
  localparam logic [CH_W-1:0] LAST = CH_W'(N_CHANNELS - 1);

  typedef struct packed {
    env_state_e             state;
    logic [SEG_W-1:0]       seg;
    logic [DUR_WIDTH-1:0]   count;
    logic                   prev_key;
  } env_voice_t;

  env_voice_t              voice_q [N_CHANNELS];
  env_voice_t              cur_voice;
  logic                    busy_q;
  logic [CH_W-1:0]         slot_q;
  logic [N_CHANNELS-1:0]   pending_q;
  logic [N_CHANNELS-1:0]   pend_eff;
  logic [N_CHANNELS-1:0]   slot_mask;
  logic [GAIN_WIDTH-1:0]   out_gain_q;
  logic [CH_W-1:0]         out_ch_q;
  logic                    out_valid_q;
  logic                    overrun_q;
  logic [N_CHANNELS-1:0]   active_c;

  env_state_e              nxt_state;
  logic [SEG_W-1:0]        nxt_seg;
  logic [DUR_WIDTH-1:0]    nxt_count;
  logic                    nxt_prev_key;
  logic [GAIN_WIDTH-1:0]   target;
  logic [GAIN_WIDTH-1:0]   gain_out;

  assign cur_voice = voice_q[slot_q];
  assign slot_mask = N_CHANNELS'(1) << slot_q;
  // A retrigger pulse landing on its own slot is consumed there, so merge before use.
  assign pend_eff  = pending_q | bus.retrigger;

  env_step #(
    .N_SEGMENTS (N_SEGMENTS),
    .SUSTAIN_SEG(SUSTAIN_SEG),
    .GAIN_WIDTH (GAIN_WIDTH),
    .DUR_WIDTH  (DUR_WIDTH)
  ) u_step (
    .cur_state   (cur_voice.state),
    .cur_seg     (cur_voice.seg),
    .cur_count   (cur_voice.count),
    .cur_prev_key(cur_voice.prev_key),
    .key         (bus.key_on[slot_q]),
    .retrig      (pend_eff[slot_q]),
    .gains       (bus.seg_gain[slot_q*VG +: VG]),
    .durs        (bus.seg_dur[slot_q*VD +: VD]),
    .nxt_state   (nxt_state),
    .nxt_seg     (nxt_seg),
    .nxt_count   (nxt_count),
    .nxt_prev_key(nxt_prev_key),
    .gain        (target)
  );

`ifdef MULTICHANNEL_ENVELOPE_SMOOTHING_EN
  localparam int unsigned SM_W = GAIN_WIDTH + 4;

  logic [SM_W-1:0]        sm_q [N_CHANNELS];
  logic signed [SM_W:0]   sm_diff;
  logic [SM_W-1:0]        sm_nxt;

  // One extra bit keeps (target<<4 - sm) signed without overflow.
  always_comb begin
    sm_diff  = $signed({1'b0, target, 4'b0000}) - $signed({1'b0, sm_q[slot_q]});
    sm_nxt   = sm_q[slot_q] + SM_W'(sm_diff >>> 4);
    gain_out = sm_nxt[SM_W-1:4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_CHANNELS; i++) sm_q[i] <= '0;
    end else if (busy_q) begin
      sm_q[slot_q] <= sm_nxt;
    end
  end
`else
  assign gain_out = target;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_CHANNELS; i++)
        voice_q[i] <= '{state: IDLE, seg: '0, count: '0, prev_key: 1'b0};
      pending_q   <= '0;
      busy_q      <= 1'b0;
      slot_q      <= '0;
      out_gain_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q   <= bus.sample_tick & busy_q;
      out_valid_q <= busy_q;
      pending_q   <= pend_eff & ~(busy_q ? slot_mask : '0);
      if (busy_q) begin
        voice_q[slot_q] <= '{state: nxt_state, seg: nxt_seg, count: nxt_count,
                             prev_key: nxt_prev_key};
        out_gain_q <= gain_out;
        out_ch_q   <= slot_q;
        if (slot_q == LAST) begin
          busy_q <= 1'b0;
          slot_q <= '0;
        end else begin
          slot_q <= slot_q + 1'b1;
        end
      end else if (bus.sample_tick) begin
        busy_q <= 1'b1;
        slot_q <= '0;
      end
    end
  end

  always_comb begin
    active_c = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++)
      active_c[i] = is_active(voice_q[i].state);
  end

  assign bus.out_gain  = out_gain_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.active    = active_c;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule
